// File: rtl/mips_mem_pkg.sv
// Shared types and encodings for the load/store unit: FSM states, access sizes,
// the registered request record and the alignment rule.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int DEFAULT_TIMEOUT_CYCLES = 256;
    localparam int NUM_LANES              = 4;

    // Everything captured when an op leaves IDLE; load formatting uses size/lane/zext later.
    typedef struct packed {
        logic                 write;
        logic [31:0]          addr;
        logic [31:0]          wdata;
        logic [NUM_LANES-1:0] byte_en;
        logic [1:0]           size;
        logic [1:0]           lane;
        logic                 zext;
    } lsu_req_t;

    // Reserved size 2'b11 follows the word rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return lane[0];
            default:   return |lane;
        endcase
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane steering: store replication and byte enables from the live
// op, load lane extraction and sign/zero extension from the captured request.
module lsu_data_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]           st_size,
    input  logic [1:0]           st_lane,
    input  logic [31:0]          st_data,
    output logic [31:0]          st_wdata,
    output logic [NUM_LANES-1:0] st_byte_en,
    input  logic [1:0]           ld_size,
    input  logic [1:0]           ld_lane,
    input  logic                 ld_zext,
    input  logic [31:0]          ld_rdata,
    output logic [31:0]          ld_data
);

    logic [NUM_LANES-1:0][7:0] st_lanes;
    logic [NUM_LANES-1:0][7:0] rd_lanes;
    logic [7:0]                ld_byte;
    logic [15:0]               ld_half;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign st_byte_en[i] = (st_size == SIZE_BYTE) ? (st_lane == 2'(i)) :
                               (st_size == SIZE_HALF) ? (st_lane[1] == 1'(i / 2)) : 1'b1;
        assign st_lanes[i]   = (st_size == SIZE_BYTE) ? st_data[7:0] :
                               (st_size == SIZE_HALF) ? st_data[8*(i%2) +: 8] : st_data[8*i +: 8];
    end

    assign st_wdata = st_lanes;
    assign rd_lanes = ld_rdata;
    assign ld_byte  = rd_lanes[ld_lane];
    assign ld_half  = ld_lane[1] ? ld_rdata[31:16] : ld_rdata[15:0];

    always_comb begin
        ld_data = ld_rdata;
        case (ld_size)
            SIZE_BYTE: ld_data = {{24{~ld_zext & ld_byte[7]}}, ld_byte};
            SIZE_HALF: ld_data = {{16{~ld_zext & ld_half[15]}}, ld_half};
            default:   ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the EX/MEM stage and a ready/valid
// memory port, with misalignment trapping and a request timeout.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_memRead_ex_mem,
    input  logic        ctrl_memWrite_ex_mem,
    input  logic [31:0] mem_address,
    input  logic [31:0] write_data_into_mem,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic        stall,
    output logic [31:0] read_data_from_mem,
    output logic        load_valid,
    output logic        misaligned_exc,
    output logic        bus_error,
    output logic        req_valid,
    output logic        req_write,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_byte_en,
    input  logic        req_ready,
    input  logic        resp_valid,
    input  logic [31:0] resp_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t state, next_state;
    lsu_req_t   req_q;
    logic [CNT_W-1:0] cnt;

    logic        any_op, misaligned, valid_op, busy, timeout;
    logic        accept, load_done;
    logic [31:0] st_wdata, ld_data;
    logic [3:0]  st_byte_en;

    assign any_op     = ctrl_memRead_ex_mem | ctrl_memWrite_ex_mem;
    assign misaligned = is_misaligned(mem_size, mem_address[1:0]);
    assign valid_op   = any_op & ~misaligned;
    assign busy       = (state == REQ) || (state == WAIT);
    assign timeout    = busy && (cnt == CNT_LAST);
    assign accept     = (state == IDLE) && valid_op;
    // A timeout outranks a coincident response so the abort path is deterministic.
    assign load_done  = (state == WAIT) && !timeout && resp_valid;

    lsu_data_align u_align (
        .st_size    (mem_size),
        .st_lane    (mem_address[1:0]),
        .st_data    (write_data_into_mem),
        .st_wdata   (st_wdata),
        .st_byte_en (st_byte_en),
        .ld_size    (req_q.size),
        .ld_lane    (req_q.lane),
        .ld_zext    (req_q.zext),
        .ld_rdata   (resp_rdata),
        .ld_data    (ld_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (valid_op) next_state = REQ;
            REQ: begin
                if (timeout)        next_state = DONE;
                else if (req_ready) next_state = req_q.write ? DONE : WAIT;
            end
            WAIT: if (timeout || resp_valid) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Stall is gated by reset so every output reads zero while reset is held.
    always_comb begin
        stall     = reset && (accept || busy);
        req_valid = (state == REQ);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt                <= '0;
            req_q              <= '0;
            read_data_from_mem <= '0;
            load_valid         <= 1'b0;
            misaligned_exc     <= 1'b0;
            bus_error          <= 1'b0;
        end else begin
            misaligned_exc <= (state == IDLE) && any_op && misaligned;
            load_valid     <= load_done;
            bus_error      <= timeout;
            if (accept) begin
                cnt           <= '0;
                req_q.write   <= ~ctrl_memRead_ex_mem;
                req_q.addr    <= {mem_address[31:2], 2'b00};
                req_q.wdata   <= st_wdata;
                req_q.byte_en <= st_byte_en;
                req_q.size    <= mem_size;
                req_q.lane    <= mem_address[1:0];
                req_q.zext    <= mem_unsigned;
            end else if (busy) begin
                cnt <= cnt + 1'b1;
            end
            if (load_done) read_data_from_mem <= ld_data;
        end
    end

    assign req_write   = req_q.write;
    assign req_addr    = req_q.addr;
    assign req_wdata   = req_q.wdata;
    assign req_byte_en = req_q.byte_en;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT_CYCLES=8): stores, loads with
// extension, misalignment, backpressure, timeout and mid-access reset.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ctrl_memRead_ex_mem, ctrl_memWrite_ex_mem;
    logic [31:0] mem_address, write_data_into_mem;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        stall;
    logic [31:0] read_data_from_mem;
    logic        load_valid, misaligned_exc, bus_error;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_byte_en;
    logic        req_ready, resp_valid;
    logic [31:0] resp_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk                  (clk),
        .reset                (reset),
        .ctrl_memRead_ex_mem  (ctrl_memRead_ex_mem),
        .ctrl_memWrite_ex_mem (ctrl_memWrite_ex_mem),
        .mem_address          (mem_address),
        .write_data_into_mem  (write_data_into_mem),
        .mem_size             (mem_size),
        .mem_unsigned         (mem_unsigned),
        .stall                (stall),
        .read_data_from_mem   (read_data_from_mem),
        .load_valid           (load_valid),
        .misaligned_exc       (misaligned_exc),
        .bus_error            (bus_error),
        .req_valid            (req_valid),
        .req_write            (req_write),
        .req_addr             (req_addr),
        .req_wdata            (req_wdata),
        .req_byte_en          (req_byte_en),
        .req_ready            (req_ready),
        .resp_valid           (resp_valid),
        .resp_rdata           (resp_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " stall"},      32'(stall),          32'h0);
        chk({tag, " rdata"},      read_data_from_mem,  32'h0);
        chk({tag, " load_valid"}, 32'(load_valid),     32'h0);
        chk({tag, " misalign"},   32'(misaligned_exc), 32'h0);
        chk({tag, " bus_error"},  32'(bus_error),      32'h0);
        chk({tag, " req_valid"},  32'(req_valid),      32'h0);
        chk({tag, " req_write"},  32'(req_write),      32'h0);
        chk({tag, " req_addr"},   req_addr,            32'h0);
        chk({tag, " req_wdata"},  req_wdata,           32'h0);
        chk({tag, " req_be"},     32'(req_byte_en),    32'h0);
    endtask

    // Store with req_ready=1: IDLE and REQ stall, DONE releases.
    task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                            input logic [3:0] be, input logic [31:0] wd, input string tag);
        ctrl_memWrite_ex_mem = 1'b1; mem_address = a; mem_size = sz;
        write_data_into_mem = d; req_ready = 1'b1; resp_valid = 1'b1;
        #4 chk({tag, " idle stall"}, 32'(stall), 32'h1);
        chk({tag, " idle req_valid"}, 32'(req_valid), 32'h0);
        cyc();
        #4 chk({tag, " req_valid"}, 32'(req_valid), 32'h1);
        chk({tag, " req_write"}, 32'(req_write), 32'h1);
        chk({tag, " req_addr"}, req_addr, {a[31:2], 2'b00});
        chk({tag, " be"}, 32'(req_byte_en), 32'(be));
        chk({tag, " wdata"}, req_wdata, wd);
        chk({tag, " req stall"}, 32'(stall), 32'h1);
        cyc();
        #4 chk({tag, " done stall"}, 32'(stall), 32'h0);
        chk({tag, " done req_valid"}, 32'(req_valid), 32'h0);
        chk({tag, " done load_valid"}, 32'(load_valid), 32'h0);
        cyc();
        ctrl_memWrite_ex_mem = 1'b0; resp_valid = 1'b0;
        #4 chk({tag, " after stall"}, 32'(stall), 32'h0);
        cyc();
    endtask

    // Load with req_ready=1 and a response one cycle after acceptance.
    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic u, input logic w,
                           input logic [31:0] rdata, input logic [3:0] be,
                           input logic [31:0] exp, input string tag);
        ctrl_memRead_ex_mem = 1'b1; ctrl_memWrite_ex_mem = w; mem_address = a;
        mem_size = sz; mem_unsigned = u; req_ready = 1'b1; resp_valid = 1'b0;
        #4 chk({tag, " idle stall"}, 32'(stall), 32'h1);
        cyc();
        resp_valid = 1'b1; resp_rdata = 32'hDEADBEEF;
        #4 chk({tag, " req_valid"}, 32'(req_valid), 32'h1);
        chk({tag, " req_write"}, 32'(req_write), 32'h0);
        chk({tag, " req_addr"}, req_addr, {a[31:2], 2'b00});
        chk({tag, " be"}, 32'(req_byte_en), 32'(be));
        cyc();
        resp_rdata = rdata;
        #4 chk({tag, " wait stall"}, 32'(stall), 32'h1);
        chk({tag, " wait req_valid"}, 32'(req_valid), 32'h0);
        cyc();
        resp_valid = 1'b0; resp_rdata = 32'h0;
        #4 chk({tag, " load_valid"}, 32'(load_valid), 32'h1);
        chk({tag, " data"}, read_data_from_mem, exp);
        chk({tag, " done stall"}, 32'(stall), 32'h0);
        cyc();
        ctrl_memRead_ex_mem = 1'b0; ctrl_memWrite_ex_mem = 1'b0;
        #4 chk({tag, " load_valid drop"}, 32'(load_valid), 32'h0);
        chk({tag, " data hold"}, read_data_from_mem, exp);
        cyc();
    endtask

    initial begin
        reset = 1'b0;
        ctrl_memRead_ex_mem = 1'b1; ctrl_memWrite_ex_mem = 1'b0;
        mem_address = 32'h0; write_data_into_mem = 32'h0;
        mem_size = 2'b10; mem_unsigned = 1'b0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = 32'h0;
        repeat (2) cyc();
        chk_all_zero("reset");
        ctrl_memRead_ex_mem = 1'b0;
        reset = 1'b1;
        cyc();

        do_store(32'h100, 2'b10, 32'h12345678, 4'b1111, 32'h12345678, "sw");
        do_store(32'h22,  2'b01, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF, "sh");
        do_store(32'h101, 2'b00, 32'h000000A5, 4'b0010, 32'hA5A5A5A5, "sb");

        do_load(32'h13, 2'b00, 1'b0, 1'b0, 32'h80FF1234, 4'b1000, 32'hFFFFFF80, "lb");
        do_load(32'h13, 2'b00, 1'b1, 1'b0, 32'h80FF1234, 4'b1000, 32'h00000080, "lbu");
        do_load(32'h12, 2'b01, 1'b0, 1'b0, 32'h80FF1234, 4'b1100, 32'hFFFF80FF, "lh");
        do_load(32'h11, 2'b00, 1'b1, 1'b0, 32'h80FF1234, 4'b0010, 32'h00000012, "lbu1");
        do_load(32'h10, 2'b10, 1'b0, 1'b1, 32'h80FF1234, 4'b1111, 32'h80FF1234, "rd+wr");

        // Misaligned word load: trap pulse, no request, no stall.
        ctrl_memRead_ex_mem = 1'b1; mem_address = 32'h22; mem_size = 2'b10;
        #4 chk("lw22 stall", 32'(stall), 32'h0);
        cyc();
        ctrl_memRead_ex_mem = 1'b0;
        #4 chk("lw22 exc", 32'(misaligned_exc), 32'h1);
        chk("lw22 req_valid", 32'(req_valid), 32'h0);
        chk("lw22 stall2", 32'(stall), 32'h0);
        cyc();
        #4 chk("lw22 exc drop", 32'(misaligned_exc), 32'h0);
        chk("lw22 req_valid2", 32'(req_valid), 32'h0);
        cyc();

        // Backpressure: req_ready low for five REQ cycles.
        ctrl_memRead_ex_mem = 1'b1; mem_address = 32'h44; mem_size = 2'b10; req_ready = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            mem_address = 32'h0;
            #4 chk("bp req_valid", 32'(req_valid), 32'h1);
            chk("bp stall", 32'(stall), 32'h1);
            chk("bp req_addr", req_addr, 32'h44);
            chk("bp be", 32'(req_byte_en), 32'hF);
            cyc();
        end
        req_ready = 1'b1;
        #4 chk("bp accept req_valid", 32'(req_valid), 32'h1);
        cyc();
        resp_valid = 1'b1; resp_rdata = 32'hCAFEF00D;
        cyc();
        resp_valid = 1'b0;
        #4 chk("bp load_valid", 32'(load_valid), 32'h1);
        chk("bp data", read_data_from_mem, 32'hCAFEF00D);
        chk("bp bus_error", 32'(bus_error), 32'h0);
        cyc();
        ctrl_memRead_ex_mem = 1'b0;
        cyc();

        // Timeout: no response ever arrives.
        ctrl_memRead_ex_mem = 1'b1; mem_address = 32'h80; mem_size = 2'b10; req_ready = 1'b1;
        cyc();
        for (int i = 0; i < 8; i++) begin
            #4 chk("to stall", 32'(stall), 32'h1);
            chk("to bus_error early", 32'(bus_error), 32'h0);
            cyc();
        end
        #4 chk("to bus_error", 32'(bus_error), 32'h1);
        chk("to stall done", 32'(stall), 32'h0);
        chk("to req_valid", 32'(req_valid), 32'h0);
        chk("to load_valid", 32'(load_valid), 32'h0);
        chk("to data", read_data_from_mem, 32'hCAFEF00D);
        cyc();
        ctrl_memRead_ex_mem = 1'b0;
        #4 chk("to bus_error drop", 32'(bus_error), 32'h0);
        cyc();

        // Reset asserted mid-WAIT, then a clean load.
        ctrl_memRead_ex_mem = 1'b1; mem_address = 32'h8; mem_size = 2'b10; req_ready = 1'b1;
        cyc();
        cyc();
        #4 chk("rst pre stall", 32'(stall), 32'h1);
        reset = 1'b0;
        #1 chk_all_zero("rst wait");
        ctrl_memRead_ex_mem = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        do_load(32'h8, 2'b10, 1'b0, 1'b0, 32'h11223344, 4'b1111, 32'h11223344, "post rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Clock and reset SHALL be one clock, `clk`; reset `reset` is asynchronous and active-low.
REQ-002 Parameter TIMEOUT_CYCLES, default 256, SHALL set the maximum cycles from request issue to completion before bus_error.
REQ-003 Ports SHALL be as follows; each line gives name, direction, width and meaning:
- clk  in  1  rising-edge clock
- reset  in  1  async active-low reset
- ctrl_memRead_ex_mem  in  1  load requested by the EX/MEM stage
- ctrl_memWrite_ex_mem  in  1  store requested by the EX/MEM stage
- mem_address  in  32  byte address
- write_data_into_mem  in  32  store data, right-justified
- mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- mem_unsigned  in  1  zero-extend loads when 1, sign-extend when 0
- stall  out  1  freeze the pipeline while the access is pending
- read_data_from_mem  out  32  formatted load result
- load_valid  out  1  one-cycle pulse when read_data_from_mem is updated
- misaligned_exc  out  1  one-cycle pulse on a misaligned access
- bus_error  out  1  one-cycle pulse on timeout
- req_valid, req_write  out  1 each  memory request handshake
- req_addr  out  32  word address, bits [1:0] = 0
- req_wdata  out  32  lane-replicated store data
- req_byte_en  out  4  byte lane enables
- req_ready  in  1  memory accepts the request
- resp_valid  in  1  read data is valid
- resp_rdata  in  32  read word

Function
REQ-004 The FSM SHALL have the states IDLE, REQ, WAIT, DONE.
REQ-005 IDLE: a valid op (read or write, aligned) SHALL move to REQ on the next edge; the request fields SHALL be registered at that edge.
REQ-006 When both read and write are asserted, the read SHALL take priority and the write SHALL be ignored.
REQ-007 Misalignment SHALL be half with addr[0]=1, or word/reserved with addr[1:0]≠0; the unit SHALL pulse misaligned_exc for 1 cycle, issue no request, assert no stall, and stay in IDLE.
REQ-008 REQ: req_valid=1 and the request fields SHALL stay stable until req_ready; on acceptance a write SHALL go to DONE and a read SHALL go to WAIT.
REQ-009 WAIT: on resp_valid the unit SHALL register the formatted data into read_data_from_mem and go to DONE; load_valid SHALL pulse in the DONE cycle.
REQ-010 DONE: stall=0 for exactly 1 cycle, then IDLE; no new op SHALL be accepted in DONE.
REQ-011 stall SHALL be combinational: 1 when (IDLE and valid aligned op), or in REQ, or in WAIT; 0 otherwise.
REQ-012 Minimum latency SHALL be: store with req_ready=1 → 2 stall cycles; load with req_ready=1 and resp_valid the next cycle → 3 stall cycles.
REQ-013 Lanes SHALL be little-endian, lane = addr[1:0]; byte_en SHALL be 0001<<addr[1:0] for byte, 0011 or 1100 for half, 1111 for word.
REQ-014 Store data SHALL be replicated: byte {4{b}}, half {2{h}}, word as-is.
REQ-015 Loads SHALL extract the addressed lane(s), then sign- or zero-extend per mem_unsigned.
REQ-016 read_data_from_mem SHALL hold its value between loads.
REQ-017 A counter SHALL run in REQ and WAIT and clear on entry to REQ; reaching TIMEOUT_CYCLES-1 SHALL force DONE with bus_error pulsed in DONE, req_valid dropped, and read_data_from_mem unchanged.
REQ-018 resp_valid outside WAIT, and req_ready outside REQ, SHALL be ignored.

Reset
REQ-019 Reset assertion SHALL immediately force IDLE, zero the counter, and zero all outputs including read_data_from_mem, aborting any in-flight request; the memory side tolerates an abandoned request.
REQ-020 Deassertion SHALL take effect at the first rising clk edge with reset=1.

Structure
REQ-021 Package mips_mem_pkg SHALL hold lsu_state_t, the SIZE_BYTE, SIZE_HALF and SIZE_WORD encodings, and the default TIMEOUT_CYCLES.
REQ-022 A combinational sub-module lsu_data_align SHALL produce store lanes, byte enables and load extraction/extension; the FSM, counter and registers SHALL stay in load_store_unit.

Verification
REQ-023 sw 0x12345678 @0x100, req_ready=1 → req_addr 0x100, be 1111, wdata 0x12345678, stall for 2 cycles.
REQ-024 lb @0x13, resp_rdata 0x80FF1234, mem_unsigned=0 → 0xFFFFFF80; with mem_unsigned=1 → 0x00000080; load_valid pulses once.
REQ-025 sh 0xBEEF @0x22 → be 1100, wdata 0xBEEFBEEF; lw @0x22 → misaligned_exc pulse, req_valid stays 0.
REQ-026 load with req_ready held low for 5 cycles → req fields stable throughout, stall=1 throughout, then normal completion.
REQ-027 TIMEOUT_CYCLES=8, resp_valid never asserted → bus_error at cycle 8, read_data_from_mem unchanged; reset pulsed during WAIT → all outputs 0, next op completes normally.
